// File: rtl/sram_adapter_pkg.sv
// sram_adapter_pkg: constants and helpers shared by the SRAM stream adapter
// and its response FIFO.
package sram_adapter_pkg;

    localparam int MAX_SRAM_LATENCY = 4;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo: fall-through response FIFO. A push into an empty FIFO is visible
// on rdata in the same cycle and is not stored if it is popped in that cycle.
module sram_rsp_fifo
    import sram_adapter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_width(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count;
    logic             stored_empty, wr_en, rd_en;

    assign stored_empty = (count == '0);
    assign empty        = stored_empty & ~push;
    assign full         = (count == FULL_C);
    assign rdata        = stored_empty ? wdata : mem[rd_ptr];
    assign wr_en        = push & ~(stored_empty & pop);
    assign rd_en        = pop & ~stored_empty;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sram_stream_adapter.sv
// sram_stream_adapter: valid/ready front-end for a fixed-latency SRAM macro with
// credit-protected response FIFO. Define SRAM_ADAPTER_WRITE_ACK_EN for write acks.
module sram_stream_adapter
    import sram_adapter_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int USER_WIDTH   = 1,
    parameter int NUM_WORDS    = 1024,
    parameter int SRAM_LATENCY = 1,
    parameter int RSP_DEPTH    = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         req_valid_i,
    output logic                         req_ready_o,
    input  logic                         req_we_i,
    input  logic [$clog2(NUM_WORDS)-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0]        req_wdata_i,
    input  logic [(DATA_WIDTH+7)/8-1:0]  req_be_i,
    input  logic [USER_WIDTH-1:0]        req_wuser_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [DATA_WIDTH-1:0]        rsp_rdata_o,
    output logic [USER_WIDTH-1:0]        rsp_ruser_o,
    output logic                         rsp_write_o,
    output logic                         sram_req_o,
    output logic                         sram_we_o,
    output logic [$clog2(NUM_WORDS)-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0]        sram_wdata_o,
    output logic [(DATA_WIDTH+7)/8-1:0]  sram_be_o,
    output logic [USER_WIDTH-1:0]        sram_wuser_o,
    input  logic [DATA_WIDTH-1:0]        sram_rdata_i,
    input  logic [USER_WIDTH-1:0]        sram_ruser_i
);

    localparam int CW = cnt_width(RSP_DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] rdata;
        logic [USER_WIDTH-1:0] ruser;
        logic                  write;
    } rsp_t;

    logic [CW-1:0]           outstanding;
    logic [SRAM_LATENCY-1:0] tag_v;
    logic                    issue, take, rsp_fire, fifo_full, fifo_empty;
    rsp_t                    push_rsp, head;

    // Ready comes only from the registered credit count, never from rsp_ready_i.
    assign req_ready_o  = outstanding < DEPTH_C;
    assign issue        = req_valid_i & req_ready_o;
    assign sram_req_o   = issue;
    assign sram_we_o    = req_we_i;
    assign sram_addr_o  = req_addr_i;
    assign sram_wdata_o = req_wdata_i;
    assign sram_be_o    = req_be_i;
    assign sram_wuser_o = req_wuser_i;
    assign rsp_valid_o  = ~fifo_empty;
    assign rsp_fire     = rsp_valid_o & rsp_ready_i;
    assign rsp_rdata_o  = head.rdata;
    assign rsp_ruser_o  = head.ruser;
    assign rsp_write_o  = head.write;

`ifdef SRAM_ADAPTER_WRITE_ACK_EN
    logic [SRAM_LATENCY-1:0] tag_w;

    assign take     = issue;
    assign push_rsp = tag_w[SRAM_LATENCY-1]
                    ? '{rdata: '0, ruser: '0, write: 1'b1}
                    : '{rdata: sram_rdata_i, ruser: sram_ruser_i, write: 1'b0};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) tag_w <= '0;
        else         tag_w <= SRAM_LATENCY'({tag_w, issue & req_we_i});
    end
`else
    assign take     = issue & ~req_we_i;
    assign push_rsp = '{rdata: sram_rdata_i, ruser: sram_ruser_i, write: 1'b0};
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tag_v       <= '0;
            outstanding <= '0;
        end else begin
            tag_v       <= SRAM_LATENCY'({tag_v, take});
            outstanding <= outstanding + CW'(take) - CW'(rsp_fire);
        end
    end

    sram_rsp_fifo #(
        .WIDTH($bits(rsp_t)),
        .DEPTH(RSP_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .push  (tag_v[SRAM_LATENCY-1]),
        .wdata (push_rsp),
        .pop   (rsp_ready_i),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Credits guarantee a returning beat always finds room.
    always @(posedge clk_i) begin
        if (rst_ni && tag_v[SRAM_LATENCY-1] && !rsp_fire) assert (!fifo_full);
    end

endmodule

// File: tb/tb_sram_stream_adapter.sv
// tb_sram_stream_adapter: randomized bench with a queue-based response model
// and a behavioural fixed-latency SRAM macro.
module tb_sram_stream_adapter;

    localparam int DW = 64;
    localparam int UW = 2;
    localparam int NW = 16;
    localparam int AW = 4;
    localparam int BW = 8;
    localparam int LAT = 2;
    localparam int DEPTH = 3;

    logic clk = 1'b0;
    logic rst_ni = 1'b1;
    logic req_valid_i = 1'b0, req_we_i = 1'b0, rsp_ready_i = 1'b0;
    logic [AW-1:0] req_addr_i = '0;
    logic [DW-1:0] req_wdata_i = '0, sram_rdata_i = '0;
    logic [BW-1:0] req_be_i = '0;
    logic [UW-1:0] req_wuser_i = '0, sram_ruser_i = '0;
    logic req_ready_o, rsp_valid_o, rsp_write_o, sram_req_o, sram_we_o;
    logic [DW-1:0] rsp_rdata_o, sram_wdata_o;
    logic [UW-1:0] rsp_ruser_o, sram_wuser_o;
    logic [AW-1:0] sram_addr_o;
    logic [BW-1:0] sram_be_o;

    always #5 clk = ~clk;

    sram_stream_adapter #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .NUM_WORDS(NW),
        .SRAM_LATENCY(LAT), .RSP_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .req_wuser_i(req_wuser_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_ruser_o(rsp_ruser_o), .rsp_write_o(rsp_write_o),
        .sram_req_o(sram_req_o), .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o),
        .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o), .sram_wuser_o(sram_wuser_o),
        .sram_rdata_i(sram_rdata_i), .sram_ruser_i(sram_ruser_i)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic          w;
        int            due;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] shadow_d[NW], mem_d[NW], pipe_d[LAT];
    logic [UW-1:0] shadow_u[NW], mem_u[NW], pipe_u[LAT];
    int            cyc = 0, n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                            input logic [BW-1:0] be);
        for (int b = 0; b < BW; b++) if (be[b]) old[b*8 +: 8] = nw[b*8 +: 8];
        return old;
    endfunction

    // One clock cycle: drive at negedge, check 1ns later, macro data changes after posedge.
    task automatic cycle(input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be,
                         input logic [UW-1:0] wu, input logic rr, output logic acc);
        logic          ev;
        logic [DW-1:0] nd;
        logic [UW-1:0] nu;
        req_valid_i = v; req_we_i = we; req_addr_i = a;
        req_wdata_i = wd; req_be_i = be; req_wuser_i = wu; rsp_ready_i = rr;
        #1;
        ev  = q.size() > 0 && q[0].due <= cyc;
        acc = v && q.size() < DEPTH;
        check("req_ready", 64'(req_ready_o), 64'(q.size() < DEPTH));
        check("sram_req", 64'(sram_req_o), 64'(acc));
        check("rsp_valid", 64'(rsp_valid_o), 64'(ev));
        if (ev) begin
            check("rsp_rdata", rsp_rdata_o, q[0].d);
            check("rsp_ruser", 64'(rsp_ruser_o), 64'(q[0].u));
            check("rsp_write", 64'(rsp_write_o), 64'(q[0].w));
        end
        if (acc) begin
            check("sram_addr", 64'(sram_addr_o), 64'(a));
            check("sram_we", 64'(sram_we_o), 64'(we));
        end
        if (ev && rr) void'(q.pop_front());
        nd = {$urandom(), $urandom()};
        nu = UW'($urandom());
        if (sram_req_o && !sram_we_o) begin
            nd = mem_d[sram_addr_o];
            nu = mem_u[sram_addr_o];
        end
        if (sram_req_o && sram_we_o) begin
            mem_d[sram_addr_o] = merge(mem_d[sram_addr_o], sram_wdata_o, sram_be_o);
            mem_u[sram_addr_o] = sram_wuser_o;
        end
        if (acc && we) begin
            shadow_d[a] = merge(shadow_d[a], wd, be);
            shadow_u[a] = wu;
`ifdef SRAM_ADAPTER_WRITE_ACK_EN
            q.push_back('{d: '0, u: '0, w: 1'b1, due: cyc + LAT});
`endif
        end
        if (acc && !we) q.push_back('{d: shadow_d[a], u: shadow_u[a], w: 1'b0, due: cyc + LAT});
        @(posedge clk);
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_d[i] = pipe_d[i-1];
            pipe_u[i] = pipe_u[i-1];
        end
        pipe_d[0] = nd;
        pipe_u[0] = nu;
        #1;
        sram_rdata_i = pipe_d[LAT-1];
        sram_ruser_i = pipe_u[LAT-1];
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        #1;
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        q.delete();
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        cyc += 2;
    endtask

    task automatic idle(input int n, input logic rr);
        logic acc;
        repeat (n) cycle(1'b0, 1'b0, '0, '0, '0, '0, rr, acc);
    endtask

    initial begin
        logic acc;
        int   n, g;
        for (int i = 0; i < NW; i++) begin
            mem_d[i] = {$urandom(), $urandom()};
            mem_u[i] = UW'($urandom());
            shadow_d[i] = mem_d[i];
            shadow_u[i] = mem_u[i];
        end
        for (int i = 0; i < LAT; i++) begin
            pipe_d[i] = '0;
            pipe_u[i] = '0;
        end
        @(negedge clk);
        do_reset();
        idle(1, 1'b1);

        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, AW'(i), '0, '0, '0, 1'b1, acc);
            check("b2b_accept", 64'(acc), 64'd1);
        end
        idle(LAT + 2, 1'b1);

        n = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, AW'(8 + n), '0, '0, '0, 1'b0, acc);
            n += int'(acc);
        end
        check("bp_accepted", 64'(n), 64'(DEPTH));
        g = 0;
        while (n < 4 && g < 50) begin
            cycle(1'b1, 1'b0, AW'(8 + n), '0, '0, '0, 1'b1, acc);
            n += int'(acc);
            g++;
        end
        check("bp_all_accepted", 64'(n), 64'd4);
        idle(LAT + DEPTH + 2, 1'b1);

        cycle(1'b1, 1'b1, AW'(5), 64'hDEAD_BEEF_CAFE_F00D, 8'h0F, UW'(1), 1'b1, acc);
        cycle(1'b1, 1'b0, AW'(5), '0, '0, '0, 1'b1, acc);
        idle(LAT + 2, 1'b1);
        check("mixed_low_word", 64'(shadow_d[5][31:0]), 64'hCAFE_F00D);

        repeat (1500) cycle($urandom_range(3) != 0, 1'($urandom()), AW'($urandom()),
                            {$urandom(), $urandom()}, BW'($urandom()), UW'($urandom()),
                            $urandom_range(3) != 0, acc);
        idle(LAT + DEPTH + 4, 1'b1);

        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, AW'(i), '0, '0, '0, 1'b0, acc);
        do_reset();
        idle(10, 1'b1);

`ifdef SRAM_ADAPTER_WRITE_ACK_EN
        cycle(1'b1, 1'b1, AW'(2), {$urandom(), $urandom()}, 8'hFF, UW'(2), 1'b0, acc);
        cycle(1'b1, 1'b0, AW'(2), '0, '0, '0, 1'b0, acc);
        cycle(1'b1, 1'b1, AW'(3), {$urandom(), $urandom()}, 8'hF0, UW'(3), 1'b0, acc);
        cycle(1'b1, 1'b1, AW'(4), {$urandom(), $urandom()}, 8'hFF, UW'(1), 1'b0, acc);
        check("wack_credit_full", 64'(acc), 64'd0);
        idle(LAT + DEPTH + 2, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
